// File: rtl/except_collector_pkg.sv
// Core-level shared types: trap cause encoding, ROB index with wrap bit,
// the flipped-bit age compare and the exception collector state encoding.
`ifndef ROB_SIZE
`define ROB_SIZE 64
`endif

package rv_trap_t;
    typedef logic [15:0] exception;
endpackage

package except_collector_pkg;
    localparam int ROB_SIZE  = `ROB_SIZE;
    localparam int ROB_IDX_W = $clog2(ROB_SIZE);

    typedef struct packed {
        logic                 flipped;
        logic [ROB_IDX_W-1:0] idx;
    } robIdx_t;

    typedef enum logic [1:0] {IDLE, PENDING, TRAP, DRAIN} excState_t;

    // Wrap-safe age compare: the flipped bit tells whether the two indices
    // sit in the same lap of the ROB, so no subtraction is needed.
    function automatic logic robIdx_older(input robIdx_t a, input robIdx_t b);
        if (a.flipped == b.flipped) begin
            return a.idx < b.idx;
        end
        return a.idx > b.idx;
    endfunction
endpackage

// File: rtl/exc_oldest_sel.sv
// Combinational pick of the oldest valid exception report; on equal age the
// lowest port number wins.
module exc_oldest_sel
    import except_collector_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int XLEN      = 64,
    localparam int PORT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                                i_vld    [NUM_PORTS],
    input  robIdx_t                             i_robIdx [NUM_PORTS],
    input  rv_trap_t::exception                 i_cause  [NUM_PORTS],
    input  logic [XLEN-1:0]                     i_tval   [NUM_PORTS],
    output logic                                o_vld,
    output logic [PORT_W-1:0]                   o_port,
    output robIdx_t                             o_robIdx,
    output rv_trap_t::exception                 o_cause,
    output logic [XLEN-1:0]                     o_tval
);

    // Ascending scan with a strict compare keeps the lowest port on ties.
    always_comb begin
        o_vld    = 1'b0;
        o_port   = '0;
        o_robIdx = '0;
        o_cause  = '0;
        o_tval   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (i_vld[p] && (!o_vld || robIdx_older(i_robIdx[p], o_robIdx))) begin
                o_vld    = 1'b1;
                o_port   = PORT_W'(p);
                o_robIdx = i_robIdx[p];
                o_cause  = i_cause[p];
                o_tval   = i_tval[p];
            end
        end
    end

endmodule

// File: rtl/except_collector.sv
// Holds the oldest reported exception, raises one trap request when the ROB
// head reaches it, then waits for the backend flush to finish.
module except_collector
    import except_collector_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int XLEN      = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS-1:0]                i_exc_vld,
    input  robIdx_t [NUM_PORTS-1:0]             i_exc_robIdx,
    input  logic [NUM_PORTS-1:0][15:0]          i_exc_cause,
    input  logic [NUM_PORTS-1:0][XLEN-1:0]      i_exc_tval,
    input  logic                                i_head_vld,
    input  robIdx_t                             i_head_robIdx,
    input  logic                                i_squash_vld,
    input  robIdx_t                             i_squash_robIdx,
    output logic                                o_trap_vld,
    output robIdx_t                             o_trap_robIdx,
    output rv_trap_t::exception                 o_trap_cause,
    output logic [XLEN-1:0]                     o_trap_tval,
    input  logic                                i_trap_rdy,
    input  logic                                i_drain_done,
    output logic                                o_busy
);

    localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic                w_selVld;
    logic [PORT_W-1:0]   w_selPort;
    robIdx_t             w_selRobIdx;
    rv_trap_t::exception w_selCause;
    logic [XLEN-1:0]     w_selTval;
    logic                w_newOlder;
    logic                w_headMatch;
    logic                w_candKilled;
    robIdx_t             w_candRobIdx;

    logic                w_portVld    [NUM_PORTS];
    robIdx_t             w_portRobIdx [NUM_PORTS];
    rv_trap_t::exception w_portCause  [NUM_PORTS];
    logic [XLEN-1:0]     w_portTval   [NUM_PORTS];

    excState_t           r_state;
    logic                r_trapVld;
    logic                r_busy;
    robIdx_t             r_heldRobIdx;
    rv_trap_t::exception r_heldCause;
    logic [XLEN-1:0]     r_heldTval;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_portVld[p]    = i_exc_vld[p];
            w_portRobIdx[p] = i_exc_robIdx[p];
            w_portCause[p]  = i_exc_cause[p];
            w_portTval[p]   = i_exc_tval[p];
        end
    end

    exc_oldest_sel #(
        .NUM_PORTS (NUM_PORTS),
        .XLEN      (XLEN)
    ) u_sel (
        .i_vld    (w_portVld),
        .i_robIdx (w_portRobIdx),
        .i_cause  (w_portCause),
        .i_tval   (w_portTval),
        .o_vld    (w_selVld),
        .o_port   (w_selPort),
        .o_robIdx (w_selRobIdx),
        .o_cause  (w_selCause),
        .o_tval   (w_selTval)
    );

    always_comb begin
        if (w_selVld) begin
            assert (i_exc_robIdx[w_selPort] == w_selRobIdx);
        end
    end

    // The squash is judged against whichever entry survives capture: if the
    // oldest candidate dies, every younger report and the held entry die too.
    assign w_headMatch  = i_head_vld && (i_head_robIdx == r_heldRobIdx);
    assign w_newOlder   = w_selVld && robIdx_older(w_selRobIdx, r_heldRobIdx);
    assign w_candRobIdx = ((r_state == IDLE) || w_newOlder) ? w_selRobIdx : r_heldRobIdx;
    assign w_candKilled = i_squash_vld && robIdx_older(i_squash_robIdx, w_candRobIdx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_trapVld    <= 1'b0;
            r_busy       <= 1'b0;
            r_heldRobIdx <= '0;
            r_heldCause  <= '0;
            r_heldTval   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_selVld && !w_candKilled) begin
                        r_state      <= PENDING;
                        r_busy       <= 1'b1;
                        r_heldRobIdx <= w_selRobIdx;
                        r_heldCause  <= w_selCause;
                        r_heldTval   <= w_selTval;
                    end
                end
                PENDING: begin
                    if (w_headMatch) begin
                        r_state   <= TRAP;
                        r_trapVld <= 1'b1;
                    end else if (w_candKilled) begin
                        r_state      <= IDLE;
                        r_busy       <= 1'b0;
                        r_heldRobIdx <= '0;
                        r_heldCause  <= '0;
                        r_heldTval   <= '0;
                    end else if (w_newOlder) begin
                        r_heldRobIdx <= w_selRobIdx;
                        r_heldCause  <= w_selCause;
                        r_heldTval   <= w_selTval;
                    end
                end
                TRAP: begin
                    if (i_trap_rdy) begin
                        r_state   <= DRAIN;
                        r_trapVld <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (i_drain_done) begin
                        r_state      <= IDLE;
                        r_busy       <= 1'b0;
                        r_heldRobIdx <= '0;
                        r_heldCause  <= '0;
                        r_heldTval   <= '0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_trapVld <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign o_trap_vld    = r_trapVld;
    assign o_busy        = r_busy;
    assign o_trap_robIdx = r_heldRobIdx;
    assign o_trap_cause  = r_heldCause;
    assign o_trap_tval   = r_heldTval;

endmodule

// File: tb/tb_except_collector.sv
// Scoreboard bench for except_collector: directed scenarios then random
// traffic, predicted by a ring-distance age model of the collector.
module tb_except_collector;
    import except_collector_pkg::*;

    localparam int NP    = 4;
    localparam int XL    = 64;
    localparam int POS_W = ROB_IDX_W + 1;
    localparam int RING  = 2 * ROB_SIZE;
    localparam int M_IDLE = 0, M_PEND = 1, M_TRAP = 2, M_DRAIN = 3;

    typedef struct {
        logic [POS_W-1:0] pos;
        logic [15:0]      cause;
        logic [XL-1:0]    tval;
    } rep_t;

    typedef struct {
        bit busy;
        bit trapVld;
        bit pop;
        bit zero;
    } exp_t;

    logic                     clk;
    logic                     rst;
    logic [NP-1:0]            excVld;
    robIdx_t [NP-1:0]         excRobIdx;
    logic [NP-1:0][15:0]      excCause;
    logic [NP-1:0][XL-1:0]    excTval;
    logic                     headVld;
    robIdx_t                  headRobIdx;
    logic                     squashVld;
    robIdx_t                  squashRobIdx;
    logic                     trapVld;
    robIdx_t                  trapRobIdx;
    logic [15:0]              trapCause;
    logic [XL-1:0]            trapTval;
    logic                     trapRdy;
    logic                     drainDone;
    logic                     busy;

    exp_t  expQ [$];
    rep_t  trapQ [$];
    int    mMode;
    rep_t  mHeld;
    int    nVectors;
    int    nMiscompares;
    logic [POS_W-1:0] base;

    except_collector #(.NUM_PORTS(NP), .XLEN(XL)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_exc_vld       (excVld),
        .i_exc_robIdx    (excRobIdx),
        .i_exc_cause     (excCause),
        .i_exc_tval      (excTval),
        .i_head_vld      (headVld),
        .i_head_robIdx   (headRobIdx),
        .i_squash_vld    (squashVld),
        .i_squash_robIdx (squashRobIdx),
        .o_trap_vld      (trapVld),
        .o_trap_robIdx   (trapRobIdx),
        .o_trap_cause    (trapCause),
        .o_trap_tval     (trapTval),
        .i_trap_rdy      (trapRdy),
        .i_drain_done    (drainDone),
        .o_busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // a is older than b when b lies less than half a ring ahead of a.
    function automatic bit isOlder(input logic [POS_W-1:0] a, input logic [POS_W-1:0] b);
        int d;
        d = (int'(b) - int'(a) + RING) % RING;
        return (d > 0) && (d < ROB_SIZE);
    endfunction

    function automatic int ri(input int flipped, input int idx);
        return flipped * ROB_SIZE + idx;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        nVectors++;
        if (act !== req) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic clearInputs();
        rst       = 1'b0;
        excVld    = '0;
        excRobIdx = '0;
        excCause  = '0;
        excTval   = '0;
        headVld   = 1'b0;
        headRobIdx = '0;
        squashVld = 1'b0;
        squashRobIdx = '0;
        trapRdy   = 1'b0;
        drainDone = 1'b0;
    endtask

    task automatic setPort(input int p, input int pos, input int cause);
        logic [POS_W-1:0] t;
        t = POS_W'(pos);
        excVld[p]    = 1'b1;
        excRobIdx[p] = t;
        excCause[p]  = 16'(cause);
        excTval[p]   = {$urandom, $urandom};
    endtask

    task automatic setHead(input int pos);
        logic [POS_W-1:0] t;
        t = POS_W'(pos);
        headVld    = 1'b1;
        headRobIdx = t;
    endtask

    task automatic setSquash(input int pos);
        logic [POS_W-1:0] t;
        t = POS_W'(pos);
        squashVld    = 1'b1;
        squashRobIdx = t;
    endtask

    // Predicts the collector's reaction to the inputs present at the next edge.
    task automatic modelStep();
        rep_t r, o, cand;
        bit found;
        logic [POS_W-1:0] sqPos, hdPos;
        exp_t e;
        found = 1'b0;
        o = '{default: 0};
        for (int p = 0; p < NP; p++) begin
            if (excVld[p]) begin
                r.pos   = excRobIdx[p];
                r.cause = excCause[p];
                r.tval  = excTval[p];
                if (!found || isOlder(r.pos, o.pos)) begin
                    o = r;
                    found = 1'b1;
                end
            end
        end
        sqPos = squashRobIdx;
        hdPos = headRobIdx;
        e = '{default: 0};
        if (rst) begin
            mMode = M_IDLE;
            mHeld = '{default: 0};
            trapQ.delete();
            e.zero = 1'b1;
        end else begin
            case (mMode)
                M_IDLE: begin
                    if (found && !(squashVld && isOlder(sqPos, o.pos))) begin
                        mHeld = o;
                        mMode = M_PEND;
                    end
                end
                M_PEND: begin
                    if (headVld && hdPos == mHeld.pos) begin
                        mMode = M_TRAP;
                        trapQ.push_back(mHeld);
                    end else begin
                        cand = mHeld;
                        if (found && isOlder(o.pos, mHeld.pos)) cand = o;
                        if (squashVld && isOlder(sqPos, cand.pos)) mMode = M_IDLE;
                        else mHeld = cand;
                    end
                end
                M_TRAP: begin
                    if (trapRdy) begin
                        mMode = M_DRAIN;
                        e.pop = 1'b1;
                    end
                end
                default: begin
                    if (drainDone) mMode = M_IDLE;
                end
            endcase
        end
        e.busy    = (mMode != M_IDLE);
        e.trapVld = (mMode == M_TRAP);
        expQ.push_back(e);
    endtask

    task automatic applyStimulus();
        modelStep();
        @(negedge clk);
        clearInputs();
    endtask

    // Monitor: one expectation per clock edge, trap payload from the trap queue.
    initial begin
        exp_t e;
        logic [POS_W-1:0] actPos;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                actPos = trapRobIdx;
                checkOutput("busy", 64'(busy), 64'(e.busy));
                checkOutput("trap_vld", 64'(trapVld), 64'(e.trapVld));
                if (e.zero) begin
                    checkOutput("reset_robIdx", 64'(actPos), 64'd0);
                    checkOutput("reset_cause", 64'(trapCause), 64'd0);
                    checkOutput("reset_tval", trapTval, 64'd0);
                end
                if (trapVld === 1'b1) begin
                    if (trapQ.size() == 0) begin
                        checkOutput("unexpected_trap", 64'(trapVld), 64'd0);
                    end else begin
                        checkOutput("trap_robIdx", 64'(actPos), 64'(trapQ[0].pos));
                        checkOutput("trap_cause", 64'(trapCause), 64'(trapQ[0].cause));
                        checkOutput("trap_tval", trapTval, trapQ[0].tval);
                    end
                end
                if (e.pop && trapQ.size() > 0) void'(trapQ.pop_front());
            end
        end
    end

    initial begin
        nVectors = 0;
        nMiscompares = 0;
        mMode = M_IDLE;
        mHeld = '{default: 0};
        base = '0;
        clearInputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b1; applyStimulus();
        rst = 1'b1; applyStimulus();

        // Oldest of two ports, head already on it: trap two edges later.
        setPort(1, ri(0, 10), 5); setPort(3, ri(0, 7), 2); applyStimulus();
        setHead(ri(0, 7)); applyStimulus();
        setHead(ri(0, 7)); applyStimulus();
        trapRdy = 1'b1; applyStimulus();
        drainDone = 1'b1; applyStimulus();

        // Wrap-around ordering.
        setPort(0, ri(0, 62), 13); applyStimulus();
        setPort(0, ri(1, 1), 5); applyStimulus();
        setPort(0, ri(0, 60), 7); applyStimulus();
        setHead(ri(0, 60)); applyStimulus();
        trapRdy = 1'b1; applyStimulus();
        drainDone = 1'b1; applyStimulus();

        // Equal-age tie goes to the lower port.
        setPort(0, ri(1, 20), 4); setPort(2, ri(1, 20), 6); applyStimulus();
        setHead(ri(1, 20)); applyStimulus();
        trapRdy = 1'b1; applyStimulus();
        drainDone = 1'b1; applyStimulus();

        // Squash behaviour.
        setPort(0, ri(0, 30), 3); applyStimulus();
        setSquash(ri(0, 25)); applyStimulus();
        setPort(0, ri(0, 30), 3); applyStimulus();
        setSquash(ri(0, 30)); applyStimulus();
        setPort(1, ri(0, 28), 9); setSquash(ri(0, 25)); applyStimulus();
        setPort(2, ri(0, 28), 9); setSquash(ri(0, 25)); applyStimulus();

        // Stalled handshake with reports arriving in TRAP and DRAIN.
        setPort(0, ri(0, 5), 1); applyStimulus();
        setHead(ri(0, 5)); applyStimulus();
        for (int i = 0; i < 3; i++) begin
            setPort(1, ri(0, 0), 11); applyStimulus();
        end
        trapRdy = 1'b1; applyStimulus();
        setPort(0, ri(0, 1), 8); applyStimulus();
        setPort(3, ri(0, 2), 8); setHead(ri(0, 2)); applyStimulus();
        drainDone = 1'b1; applyStimulus();
        applyStimulus();

        // Reset while trapping discards the held exception.
        setPort(0, ri(0, 9), 12); applyStimulus();
        setHead(ri(0, 9)); applyStimulus();
        rst = 1'b1; applyStimulus();
        for (int i = 0; i < 3; i++) begin
            setHead(ri(0, 9)); applyStimulus();
        end

        // Random traffic in a sliding ROB window.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 15) == 0) base = base + POS_W'($urandom_range(1, 8));
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(0, 3) == 0)
                    setPort(p, int'(base) + int'($urandom_range(0, 24)), int'($urandom_range(0, 65535)));
            end
            if (mMode == M_PEND && $urandom_range(0, 1) == 0) setHead(int'(mHeld.pos));
            else if ($urandom_range(0, 1) == 0) setHead(int'(base) + int'($urandom_range(0, 24)));
            if ($urandom_range(0, 7) == 0) setSquash(int'(base) + int'($urandom_range(0, 24)));
            trapRdy   = ($urandom_range(0, 1) == 0);
            drainDone = ($urandom_range(0, 2) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            applyStimulus();
        end

        rst = 1'b1; applyStimulus();
        for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (expQ.size() != 0) checkOutput("expect_queue_drained", 64'(expQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
